pipelined_muldiv_alu: RTL and testbench
=======================================

Name: pipelined_muldiv_alu

Overview:
Parametrised-width execution unit for the MIPS datapath. Single-cycle ALU ops (add/sub/logic/slt) return a registered result one cycle after issue. Iterative signed/unsigned multiply and divide write architectural HI/LO registers, with mfhi/mflo readback. A valid/ready handshake stalls issue while a multi-cycle operation is in flight, so the control unit can hold the pipeline.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  unit can accept; issue fires when in_valid&&in_ready at a rising edge
op  in  4  operation code (see Behaviour)
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm)
out_valid  out  1  one-cycle pulse: y/zero/div_by_zero valid
y  out  WIDTH  result
zero  out  1  y == 0
div_by_zero  out  1  qualifies out_valid for div/divu with b==0
hi  out  WIDTH  HI register (continuous view)
lo  out  WIDTH  LO register (continuous view)
busy  out  1  multi-cycle op in flight (== !in_ready)

Behaviour:
- Reset (async, rst_n low): state IDLE, in_ready=1, busy=0, out_valid=0, y=0, zero=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts it; HI/LO are cleared, not partially written.
- Op codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt (signed), 7 sltu, 8 mult, 9 multu, A div, B divu, C mfhi, D mflo, E/F reserved -> y=0, zero=1, no HI/LO change.
- Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu give y = {WIDTH-1 zeros, bit}.
- zero is recomputed from the final y for every op, including mult/div where y=lo.
- Single-cycle ops (0-7, C, D, E, F): accepted at edge N; y, zero, out_valid=1 registered at N; out_valid drops at N+1 unless another issue occurs. Back-to-back issue every cycle is allowed. in_ready stays 1.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: mult/multu -> MUL; div/divu with b!=0 -> DIV. Operand magnitudes are latched (abs value for signed ops), result signs are latched, counter=0, in_ready=0.
  - MUL: shift-add, one bit per cycle. DIV: restoring, one quotient bit per cycle. After WIDTH iterations -> FIX.
  - FIX: two's-complement sign correction. Product sign = sa^sb. Quotient sign = sa^sb; remainder sign = sa.
  - FIX then writes hi=product[2W-1:W], lo=product[W-1:0] (mul), or lo=quotient, hi=remainder (div). It sets y=lo and out_valid=1, returns to IDLE, and sets in_ready=1 in that same cycle.
- Latency: accept at edge N; out_valid high after edge N+WIDTH+1 (33 edges for WIDTH=32). in_ready is low for WIDTH+1 cycles.
- Divide by zero (div/divu, b==0): no iteration. At edge N: lo={WIDTH{1}}, hi=a, y=lo, out_valid=1, div_by_zero=1; in_ready stays 1.
- Signed overflow div of -2^(W-1) by -1: lo=-2^(W-1), hi=0, div_by_zero=0.
- in_valid while in_ready=0 is ignored; the issuer holds op/a/b until accepted.
- No output back-pressure: out_valid is a pulse, and the consumer must capture it.
- mfhi/mflo issued in the cycle after a mul/div completes return the newly written HI/LO.

Decomposition:
- Shared package alu_pkg: op code localparams (OP_ADD..OP_MFLO), FSM state encoding, and the WIDTH default constant.
- One sub-module, seq_muldiv_core: holds the counter, the shift registers and the MUL/DIV/FIX sequencing with start/done. The top keeps the single-cycle ALU, handshake and HI/LO.

Test Plan:
- add a=5, b=0xFFFFFFFB -> next cycle out_valid=1, y=0, zero=1; sltu a=1, b=0xFFFFFFFF issued back-to-back -> y=1, zero=0.
- mult a=0xFFFFFFFD (-3), b=7 -> in_ready low 33 cycles; out_valid 33 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; then mfhi -> y=0xFFFFFFFF.
- divu a=100, b=7 -> lo=14, hi=2, y=14; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=42, b=0 -> out_valid next cycle, div_by_zero=1, lo=0xFFFFFFFF, hi=42, in_ready never drops; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- multu 0xFFFFFFFF*0xFFFFFFFF, rst_n pulsed low at iteration 10 -> hi=lo=0, in_ready=1, out_valid never pulses; the next add works normally.
- WIDTH=8 instance: mult -128*-1 -> hi=0x00, lo=0x80 after 9 edges; in_valid held during busy -> exactly one acceptance.

Source files
------------

// File: rtl/pipelined_muldiv_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op codes, FSM state encoding and default width for the
//               pipelined multiply/divide ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_WIDTH = 32;

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_AND   = 4'h2;
    localparam logic [3:0] c_OP_OR    = 4'h3;
    localparam logic [3:0] c_OP_XOR   = 4'h4;
    localparam logic [3:0] c_OP_NOR   = 4'h5;
    localparam logic [3:0] c_OP_SLT   = 4'h6;
    localparam logic [3:0] c_OP_SLTU  = 4'h7;
    localparam logic [3:0] c_OP_MULT  = 4'h8;
    localparam logic [3:0] c_OP_MULTU = 4'h9;
    localparam logic [3:0] c_OP_DIV   = 4'hA;
    localparam logic [3:0] c_OP_DIVU  = 4'hB;
    localparam logic [3:0] c_OP_MFHI  = 4'hC;
    localparam logic [3:0] c_OP_MFLO  = 4'hD;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_MUL  = 2'd1;
    localparam state_t c_ST_DIV  = 2'd2;
    localparam state_t c_ST_FIX  = 2'd3;

    // Even mul/div codes (mult, div) are the signed variants.
    function automatic logic op_is_signed(input logic [3:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_muldiv_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_muldiv_alu_if
// Description : Issue/result bus of the execution unit (valid/ready issue,
//               pulsed result, HI/LO view).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_muldiv_alu_if #(
    parameter int WIDTH = alu_pkg::c_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, y, zero, div_by_zero, hi, lo, busy
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, y, zero, div_by_zero, hi, lo, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_core
// Description : Iterative shift-add multiplier / restoring divider with a
//               final sign-correction state; one result bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             is_div,
    input  wire logic             is_signed,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      res_hi,
    output logic [WIDTH-1:0]      res_lo
);

    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_ma    = w_a_neg ? -a : a;
    assign w_mb    = w_b_neg ? -b : b;

    // r_hi:r_lo is the product register (mul) or remainder:quotient (div).
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
    assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ok  = (w_div_sh >= {1'b0, r_mb});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = is_div ? c_ST_DIV : c_ST_MUL;
            c_ST_MUL,
            c_ST_DIV:  if (r_cnt == c_LAST) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mb     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= is_div ? w_ma : w_mb;
                        r_mb     <= is_div ? w_mb : w_ma;
                        r_is_div <= is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                    end
                end
                c_ST_MUL: begin
                    r_hi  <= w_mul_sum[WIDTH:1];
                    r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                c_ST_DIV: begin
                    r_hi  <= w_div_ok ? WIDTH'(w_div_sh - {1'b0, r_mb}) : w_div_sh[WIDTH-1:0];
                    r_lo  <= {r_lo[WIDTH-2:0], w_div_ok};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Sign correction is applied combinationally while in FIX; the top
    // captures it on the FIX->IDLE edge.
    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign res_hi = r_is_div ? (r_neg_r ? -r_hi : r_hi) : w_prod[2*WIDTH-1:WIDTH];
    assign res_lo = r_is_div ? (r_neg_q ? -r_lo : r_lo) : w_prod[WIDTH-1:0];
    assign busy   = (r_state != c_ST_IDLE);
    assign done   = (r_state == c_ST_FIX);

endmodule
`default_nettype wire

// File: rtl/pipelined_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_muldiv_alu
// Description : MIPS execution unit: registered single-cycle ALU, iterative
//               mul/div into HI/LO, mfhi/mflo, valid/ready issue stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_muldiv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst_n,
    pipelined_muldiv_alu_if.slave bus
);

    logic             w_core_busy;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic             w_issue;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_start;
    logic             w_dbz;
    logic [WIDTH-1:0] w_alu_y;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign w_issue  = bus.in_valid & ~w_core_busy;
    assign w_is_mul = (bus.op == c_OP_MULT) | (bus.op == c_OP_MULTU);
    assign w_is_div = (bus.op == c_OP_DIV)  | (bus.op == c_OP_DIVU);
    // Divide by zero never enters the iterative core.
    assign w_start  = w_issue & (w_is_mul | (w_is_div & (bus.b != '0)));
    assign w_dbz    = w_issue & w_is_div & (bus.b == '0);

    seq_muldiv_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_start),
        .is_div    (w_is_div),
        .is_signed (op_is_signed(bus.op)),
        .a         (bus.a),
        .b         (bus.b),
        .busy      (w_core_busy),
        .done      (w_core_done),
        .res_hi    (w_core_hi),
        .res_lo    (w_core_lo)
    );

    always_comb begin
        w_alu_y = '0;
        case (bus.op)
            c_OP_ADD:  w_alu_y = bus.a + bus.b;
            c_OP_SUB:  w_alu_y = bus.a - bus.b;
            c_OP_AND:  w_alu_y = bus.a & bus.b;
            c_OP_OR:   w_alu_y = bus.a | bus.b;
            c_OP_XOR:  w_alu_y = bus.a ^ bus.b;
            c_OP_NOR:  w_alu_y = ~(bus.a | bus.b);
            c_OP_SLT:  w_alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_OP_SLTU: w_alu_y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            c_OP_MFHI: w_alu_y = r_hi;
            c_OP_MFLO: w_alu_y = r_lo;
            default:   w_alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            if (w_core_done) begin
                r_hi        <= w_core_hi;
                r_lo        <= w_core_lo;
                r_y         <= w_core_lo;
                r_zero      <= (w_core_lo == '0);
                r_out_valid <= 1'b1;
            end else if (w_dbz) begin
                r_hi        <= bus.a;
                r_lo        <= '1;
                r_y         <= '1;
                r_zero      <= 1'b0;
                r_out_valid <= 1'b1;
                r_dbz       <= 1'b1;
            end else if (w_issue && !w_start) begin
                r_y         <= w_alu_y;
                r_zero      <= (w_alu_y == '0);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = ~w_core_busy;
    assign bus.busy        = w_core_busy;
    assign bus.out_valid   = r_out_valid;
    assign bus.y           = r_y;
    assign bus.zero        = r_zero;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_muldiv_alu
// Description : Self-checking bench: directed table, corner sequences and
//               random ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_muldiv_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic [3:0]  drv_op = '0;
    logic [63:0] drv_a = '0;
    logic [63:0] drv_b = '0;

    int total = 0;
    int bad = 0;
    logic [63:0] m_hi [2] = '{64'd0, 64'd0};
    logic [63:0] m_lo [2] = '{64'd0, 64'd0};

    always #5 clk = ~clk;

    pipelined_muldiv_alu_if #(.WIDTH(32)) bus32 ();
    pipelined_muldiv_alu_if #(.WIDTH(8))  bus8 ();

    assign bus32.in_valid = drv_valid & ~sel;
    assign bus32.op       = drv_op;
    assign bus32.a        = drv_a[31:0];
    assign bus32.b        = drv_b[31:0];
    assign bus8.in_valid  = drv_valid & sel;
    assign bus8.op        = drv_op;
    assign bus8.a         = drv_a[7:0];
    assign bus8.b         = drv_b[7:0];

    pipelined_muldiv_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pipelined_muldiv_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    logic [63:0] v_y, v_hi, v_lo;
    logic        v_rdy, v_ov, v_zero, v_dbz, v_busy;

    always_comb begin
        if (sel) begin
            v_y = {56'd0, bus8.y};   v_hi = {56'd0, bus8.hi};  v_lo = {56'd0, bus8.lo};
            v_rdy = bus8.in_ready;   v_ov = bus8.out_valid;    v_zero = bus8.zero;
            v_dbz = bus8.div_by_zero; v_busy = bus8.busy;
        end else begin
            v_y = {32'd0, bus32.y};  v_hi = {32'd0, bus32.hi}; v_lo = {32'd0, bus32.lo};
            v_rdy = bus32.in_ready;  v_ov = bus32.out_valid;   v_zero = bus32.zero;
            v_dbz = bus32.div_by_zero; v_busy = bus32.busy;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural model: plain integer arithmetic on w-bit values.
    task automatic ref_model(input logic [3:0] op, input logic [63:0] ai, input logic [63:0] bi,
                             input int w, inout logic [63:0] hi, inout logic [63:0] lo,
                             output logic [63:0] y, output logic dbz, output int lat);
        logic [63:0] mask, a, b, up;
        longint sa, sb, sp;
        mask = (64'd1 << w) - 64'd1;
        a = ai & mask;
        b = bi & mask;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        y = '0; dbz = 1'b0; lat = 0;
        case (op)
            4'h0: y = (a + b) & mask;
            4'h1: y = (a - b) & mask;
            4'h2: y = a & b;
            4'h3: y = a | b;
            4'h4: y = a ^ b;
            4'h5: y = ~(a | b) & mask;
            4'h6: y = (sa < sb) ? 64'd1 : 64'd0;
            4'h7: y = (a < b) ? 64'd1 : 64'd0;
            4'h8: begin
                sp = sa * sb;
                hi = (64'(sp) >> w) & mask; lo = 64'(sp) & mask; y = lo; lat = w + 1;
            end
            4'h9: begin
                up = a * b;
                hi = (up >> w) & mask; lo = up & mask; y = lo; lat = w + 1;
            end
            4'hA, 4'hB: begin
                if (b == 0) begin
                    lo = mask; hi = a; dbz = 1'b1;
                end else if (op == 4'hA) begin
                    lo = 64'(sa / sb) & mask; hi = 64'(sa % sb) & mask; lat = w + 1;
                end else begin
                    lo = a / b; hi = a % b; lat = w + 1;
                end
                y = lo;
            end
            4'hC: y = hi;
            4'hD: y = lo;
            default: y = '0;
        endcase
    endtask

    task automatic exec(input string nm, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit use_tab, input logic [63:0] tab_y);
        logic [63:0] ey;
        logic        edbz;
        int          elat, lat, busy_cyc, w;
        bit          busy_ok;
        w = sel ? 8 : 32;
        ref_model(op, a, b, w, m_hi[sel], m_lo[sel], ey, edbz, elat);
        @(negedge clk);
        drv_op = op; drv_a = a; drv_b = b; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 0; busy_cyc = 0; busy_ok = 1'b1;
        while (!v_ov && lat < 100) begin
            if (!v_rdy) busy_cyc++;
            if (v_busy == v_rdy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s.latency", nm), 64'(lat), 64'(elat));
        chk($sformatf("%s.ready_low", nm), 64'(busy_cyc), 64'(elat));
        chk($sformatf("%s.busy_vs_ready", nm), 64'(busy_ok), 64'd1);
        chk($sformatf("%s.y", nm), v_y, ey);
        if (use_tab) chk($sformatf("%s.y_table", nm), v_y, tab_y);
        chk($sformatf("%s.zero", nm), 64'(v_zero), 64'(ey == 0));
        chk($sformatf("%s.hi", nm), v_hi, m_hi[sel]);
        chk($sformatf("%s.lo", nm), v_lo, m_lo[sel]);
        chk($sformatf("%s.dbz", nm), 64'(v_dbz), 64'(edbz));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t tab [25];

    function automatic logic [63:0] pick(input int sz);
        logic [63:0] r;
        case ($urandom_range(0, 7))
            0: r = 64'd0;
            1: r = 64'd1;
            2: r = 64'd1 << (sz - 1);
            3: r = (64'd1 << sz) - 64'd1;
            default: r = {$urandom, $urandom};
        endcase
        return r & ((64'd1 << sz) - 64'd1);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, pulses, ov_at;
        logic [63:0] ey;
        logic        edbz;
        int          elat;

        tab[0]  = '{4'h0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000};
        tab[1]  = '{4'h7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        tab[2]  = '{4'h1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        tab[3]  = '{4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
        tab[4]  = '{4'h3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
        tab[5]  = '{4'h4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
        tab[6]  = '{4'h5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        tab[7]  = '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tab[8]  = '{4'h6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[9]  = '{4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tab[10] = '{4'h8, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};
        tab[11] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        tab[12] = '{4'hB, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
        tab[13] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
        tab[14] = '{4'hA, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        tab[15] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        tab[16] = '{4'hA, 32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFF};
        tab[17] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'h0000_002A};
        tab[18] = '{4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tab[19] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tab[20] = '{4'hE, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};
        tab[21] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tab[22] = '{4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tab[23] = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
        tab[24] = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};

        #12;
        chk("reset.in_ready", 64'(v_rdy), 64'd1);
        chk("reset.busy", 64'(v_busy), 64'd0);
        chk("reset.out_valid", 64'(v_ov), 64'd0);
        chk("reset.y", v_y, 64'd0);
        chk("reset.zero", 64'(v_zero), 64'd0);
        chk("reset.dbz", 64'(v_dbz), 64'd0);
        chk("reset.hi", v_hi, 64'd0);
        chk("reset.lo", v_lo, 64'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 25; i++)
            exec($sformatf("tab%0d", i), tab[i].op, 64'(tab[i].a), 64'(tab[i].b), 1'b1, 64'(tab[i].y));

        // Result pulse lasts one cycle when nothing else is issued.
        @(posedge clk); #1;
        chk("pulse_drop.out_valid", 64'(v_ov), 64'd0);

        // Reset in the middle of a multiply aborts it cleanly.
        @(negedge clk);
        drv_op = 4'h9; drv_a = 64'hFFFF_FFFF; drv_b = 64'hFFFF_FFFF; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("abort.hi", v_hi, 64'd0);
        chk("abort.lo", v_lo, 64'd0);
        chk("abort.in_ready", 64'(v_rdy), 64'd1);
        chk("abort.out_valid", 64'(v_ov), 64'd0);
        m_hi = '{64'd0, 64'd0};
        m_lo = '{64'd0, 64'd0};
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (v_ov) pulses++;
        end
        chk("abort.no_pulse", 64'(pulses), 64'd0);
        exec("abort.add", 4'h0, 64'd2, 64'd3, 1'b1, 64'd5);

        for (int i = 0; i < 150; i++)
            exec($sformatf("rnd32_%0d", i), 4'($urandom_range(0, 15)), pick(32), pick(32), 1'b0, 64'd0);

        // WIDTH=8: in_valid held through the busy window is accepted once.
        sel = 1'b1;
        ref_model(4'h8, 64'h80, 64'hFF, 8, m_hi[1], m_lo[1], ey, edbz, elat);
        acc = 0; pulses = 0; ov_at = -1;
        @(negedge clk);
        drv_op = 4'h8; drv_a = 64'h80; drv_b = 64'hFF; drv_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 6) drv_valid = 1'b0;
            if (v_ov) begin
                pulses++;
                ov_at = i;
            end
            if (drv_valid && v_rdy) acc++;
        end
        chk("w8_hold.accepts", 64'(acc), 64'd1);
        chk("w8_hold.pulses", 64'(pulses), 64'd1);
        chk("w8_hold.edge_of_result", 64'(ov_at), 64'd10);
        chk("w8_hold.hi", v_hi, 64'h00);
        chk("w8_hold.lo", v_lo, 64'h80);
        chk("w8_hold.model_lo", v_lo, m_lo[1]);

        exec("w8.mfhi", 4'hC, 64'd0, 64'd0, 1'b1, 64'h00);
        for (int i = 0; i < 60; i++)
            exec($sformatf("rnd8_%0d", i), 4'($urandom_range(0, 15)), pick(8), pick(8), 1'b0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
